date_counter: RTL and testbench
===============================

// Module: date_counter
// PURPOSE
//  Calendar core for the date-display lab: holds day/month/year as packed BCD and advances one day per tick.
//  Covers years 2000-2099 (two-digit year) with leap-year February.
//  Feeds the BCD-to-SSD decoders whose outputs drive display_controller (day/month digits, year digits).
//  Also accepts a synchronous date load from the switch/setting logic.
// PARAMETERS
//  DAY_RST    8'h01  packed BCD day after reset
//  MONTH_RST  8'h01  packed BCD month after reset
//  YEAR_RST   8'h00  packed BCD year (20YY) after reset
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  asynchronous reset, active-high
//  tick       in   1  advance one day; 1-cycle pulse from the prescaler
//  load       in   1  load load_day/load_month/load_year this cycle
//  load_day   in   8  packed BCD {tens,units}
//  load_month in   8  packed BCD
//  load_year  in   8  packed BCD
//  day1       out  4  BCD day tens     day0   out 4 BCD day units
//  month1     out  4  BCD month tens   month0 out 4 BCD month units
//  year1      out  4  BCD year tens    year0  out 4 BCD year units
//  year_wrap  out  1  1-cycle pulse when 99-12-31 rolls to 00-01-01
//  load_err   out  1  1-cycle pulse, rejected load (DATE_LOAD_CHECK_EN only)
// BEHAVIOUR
//  - Reset: one clock; reset is asynchronous and active-high. rst forces day={DAY_RST}, month={MONTH_RST},
//    year={YEAR_RST}, year_wrap=0, load_err=0, immediately (no clk needed).
//  - All outputs registered; tick/load sampled at posedge, new date visible the following cycle (latency 1).
//  - Priority per edge: load > tick. Simultaneous load+tick: load taken, tick dropped (not queued).
//  - Month length: 01,03,05,07,08,10,12 -> 31; 04,06,09,11 -> 30; 02 -> 29 if leap else 28.
//  - Leap, computed on BCD year directly: (year1 even AND year0 in {0,4,8}) OR (year1 odd AND year0 in {2,6}).
//    Year 00 (2000) is leap.
//  - Day step on tick: if day >= month_len -> day=01, month step; else day+1 in BCD (units 9 -> 0, tens+1).
//  - Month step: if month >= 12 -> month=01, year step; else month+1 in BCD (09 -> 10).
//  - Year step: 99 -> 00 with year_wrap=1 for exactly that cycle; else year+1 in BCD.
//  - Comparisons use >= so an out-of-range date (only reachable by unchecked load) self-corrects on next tick.
//  - No internal state beyond the six digit registers and two pulse flops; no FSM hold states.
//  - year_wrap and load_err deassert the cycle after they assert; never stretched.
// CONFIGURATION
//  DATE_LOAD_CHECK_EN defined:
//   - Load validated: every nibble <= 9, month 01..12, day 01..month_len(load_month, load_year).
//   - Invalid load: date unchanged, load_err=1 one cycle; tick in same cycle still dropped.
//  DATE_LOAD_CHECK_EN undefined:
//   - Load accepted unconditionally; load_err tied 0; check logic absent.
// TESTING
//  1 rst=1 mid-count (date 15-07-23) -> outputs 01-01-00 async, before next clk edge; year_wrap=0.
//  2 load 28-02-23, tick -> 01-03-23; load 28-02-24, tick -> 29-02-24, tick -> 01-03-24.
//  3 load 31-12-99, tick -> 01-01-00 and year_wrap=1 for exactly 1 cycle.
//  4 load 09-09-19 + tick same cycle -> 09-09-19 (tick dropped); next tick -> 10-09-19.
//  5 (CHECK_EN) load 31-04-25 -> date unchanged, load_err=1 one cycle; load 30-04-25 -> accepted, load_err=0.
//  6 (no CHECK_EN) load 31-04-25 accepted; tick -> 01-05-25; 366 ticks from 01-01-00 -> 01-01-01.

Source files
------------

// File: rtl/date_counter.sv
// date_counter: calendar core for the date display. Holds day/month/year as packed BCD
// (years 2000-2099, two-digit year) and advances one day per tick, with leap-year February.
// Also accepts a synchronous date load, which takes priority over tick in the same cycle.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   tick                          advance one day (1-cycle pulse)
//   load                          load load_day/load_month/load_year this cycle
//   load_day/month/year [7:0]     packed BCD {tens, units}
//   day1/day0, month1/month0,
//   year1/year0 [3:0]             registered BCD digits of the current date
//   year_wrap                     1-cycle pulse when 99-12-31 rolls over to 00-01-01
//   load_err                      1-cycle pulse on a rejected load
//
// Build option: define DATE_LOAD_CHECK_EN to validate loads (each nibble <= 9, month 01..12,
// day 01..month length). Without it every load is accepted and load_err is tied low.

module date_counter #(
  parameter logic [7:0] DAY_RST   = 8'h01,
  parameter logic [7:0] MONTH_RST = 8'h01,
  parameter logic [7:0] YEAR_RST  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_day,
  input  logic [7:0] load_month,
  input  logic [7:0] load_year,
  output logic [3:0] day1,
  output logic [3:0] day0,
  output logic [3:0] month1,
  output logic [3:0] month0,
  output logic [3:0] year1,
  output logic [3:0] year0,
  output logic       year_wrap,
  output logic       load_err
);

  // Leap test on the BCD digits directly: a two-digit year is a multiple of four when the
  // tens digit is even and units in {0,4,8}, or tens is odd and units in {2,6}.
  function automatic logic is_leap(input logic [3:0] y1, input logic [3:0] y0);
    if (!y1[0]) begin
      return (y0 == 4'd0) || (y0 == 4'd4) || (y0 == 4'd8);
    end else begin
      return (y0 == 4'd2) || (y0 == 4'd6);
    end
  endfunction

  // Month length as packed BCD. Out-of-range months fall into the 31-day default.
  function automatic logic [7:0] month_len(input logic [7:0] month, input logic [7:0] year);
    case (month)
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      8'h02:                      return is_leap(year[7:4], year[3:0]) ? 8'h29 : 8'h28;
      default:                    return 8'h31;
    endcase
  endfunction

  // Packed-BCD increment; >= keeps an illegal units nibble from sticking.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] >= 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  logic [3:0] r_day1, r_day0, r_month1, r_month0, r_year1, r_year0;
  logic       r_year_wrap;

  logic [7:0] w_day, w_month, w_year, w_len;
  logic [7:0] w_day_n, w_month_n, w_year_n;
  logic       w_wrap_n;

  assign w_day   = {r_day1, r_day0};
  assign w_month = {r_month1, r_month0};
  assign w_year  = {r_year1, r_year0};
  assign w_len   = month_len(w_month, w_year);

`ifdef DATE_LOAD_CHECK_EN
  logic       r_load_err;
  logic       w_err_n;
  logic       w_load_nib_ok;
  logic       w_load_ok;
  logic [7:0] w_load_len;

  assign w_load_nib_ok = (load_day[7:4] <= 4'd9) && (load_day[3:0] <= 4'd9) &&
                         (load_month[7:4] <= 4'd9) && (load_month[3:0] <= 4'd9) &&
                         (load_year[7:4] <= 4'd9) && (load_year[3:0] <= 4'd9);
  assign w_load_len    = month_len(load_month, load_year);
  assign w_load_ok     = w_load_nib_ok &&
                         (load_month >= 8'h01) && (load_month <= 8'h12) &&
                         (load_day >= 8'h01) && (load_day <= w_load_len);
`endif

  always_comb begin
    w_day_n   = w_day;
    w_month_n = w_month;
    w_year_n  = w_year;
    w_wrap_n  = 1'b0;
`ifdef DATE_LOAD_CHECK_EN
    w_err_n   = 1'b0;
`endif
    if (load) begin
      // A load always consumes the cycle; a coincident tick is dropped even if rejected.
`ifdef DATE_LOAD_CHECK_EN
      if (w_load_ok) begin
        w_day_n   = load_day;
        w_month_n = load_month;
        w_year_n  = load_year;
      end else begin
        w_err_n = 1'b1;
      end
`else
      w_day_n   = load_day;
      w_month_n = load_month;
      w_year_n  = load_year;
`endif
    end else if (tick) begin
      // >= so an out-of-range loaded date snaps back to a legal one on the next tick.
      if (w_day >= w_len) begin
        w_day_n = 8'h01;
        if (w_month >= 8'h12) begin
          w_month_n = 8'h01;
          if (w_year >= 8'h99) begin
            w_year_n = 8'h00;
            w_wrap_n = 1'b1;
          end else begin
            w_year_n = bcd_inc(w_year);
          end
        end else begin
          w_month_n = bcd_inc(w_month);
        end
      end else begin
        w_day_n = bcd_inc(w_day);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_day1, r_day0}     <= DAY_RST;
      {r_month1, r_month0} <= MONTH_RST;
      {r_year1, r_year0}   <= YEAR_RST;
      r_year_wrap          <= 1'b0;
    end else begin
      {r_day1, r_day0}     <= w_day_n;
      {r_month1, r_month0} <= w_month_n;
      {r_year1, r_year0}   <= w_year_n;
      r_year_wrap          <= w_wrap_n;
    end
  end

`ifdef DATE_LOAD_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= w_err_n;
    end
  end
  assign load_err = r_load_err;
`else
  assign load_err = 1'b0;
`endif

  assign day1      = r_day1;
  assign day0      = r_day0;
  assign month1    = r_month1;
  assign month0    = r_month0;
  assign year1     = r_year1;
  assign year0     = r_year0;
  assign year_wrap = r_year_wrap;

endmodule

// File: tb/tb_date_counter.sv
// Bench for date_counter: directed steps in one initial block. Each step drives inputs on the
// falling edge, pushes the expected registered result to a scoreboard queue, and after the
// next rising edge pops and compares it. Dates are written as packed {DD, MM, YY} BCD.

module tb_date_counter;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       load;
  logic [7:0] load_day, load_month, load_year;
  logic [3:0] day1, day0, month1, month0, year1, year0;
  logic       year_wrap;
  logic       load_err;

  typedef struct {
    string       tag;
    logic [23:0] date;
    logic        wrap;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  date_counter dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .load      (load),
    .load_day  (load_day),
    .load_month(load_month),
    .load_year (load_year),
    .day1      (day1),
    .day0      (day0),
    .month1    (month1),
    .month0    (month0),
    .year1     (year1),
    .year0     (year0),
    .year_wrap (year_wrap),
    .load_err  (load_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic expect_push(input string tag, input logic [23:0] date, input logic wrap,
                             input logic err);
    exp_t e;
    e.tag  = tag;
    e.date = date;
    e.wrap = wrap;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t        e;
    logic [23:0] obs;
    if (sb.size() == 0) begin
      n_checks++;
      $error("FAIL scoreboard: observed empty queue, required an entry");
      return;
    end
    e   = sb.pop_front();
    obs = {day1, day0, month1, month0, year1, year0};
    n_checks++;
    assert (obs === e.date) n_pass++;
    else $error("FAIL %s date: observed %h required %h", e.tag, obs, e.date);
    n_checks++;
    assert (year_wrap === e.wrap) n_pass++;
    else $error("FAIL %s year_wrap: observed %b required %b", e.tag, year_wrap, e.wrap);
    n_checks++;
    assert (load_err === e.err) n_pass++;
    else $error("FAIL %s load_err: observed %b required %b", e.tag, load_err, e.err);
  endtask

  // One clock of stimulus; chk selects whether this step's result is scored.
  task automatic step(input string tag, input logic t, input logic l, input logic [23:0] ld,
                      input logic chk, input logic [23:0] edate, input logic ewrap,
                      input logic eerr);
    @(negedge clk);
    tick = t;
    load = l;
    {load_day, load_month, load_year} = ld;
    if (chk) expect_push(tag, edate, ewrap, eerr);
    @(posedge clk);
    #1;
    tick = 1'b0;
    load = 1'b0;
    if (chk) compare();
  endtask

  initial begin
    tick = 1'b0;
    load = 1'b0;
    {load_day, load_month, load_year} = 24'h0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    // Reset must act before the first clock edge.
    expect_push("por", 24'h010100, 1'b0, 1'b0);
    compare();
    @(negedge clk);
    rst = 1'b0;

    // 1: asynchronous reset in the middle of counting
    step("ld140723", 1'b0, 1'b1, 24'h140723, 1'b1, 24'h140723, 1'b0, 1'b0);
    step("tk150723", 1'b1, 1'b0, 24'h0,      1'b1, 24'h150723, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    expect_push("async_rst", 24'h010100, 1'b0, 1'b0);
    compare();
    #1 rst = 1'b0;

    // 2: February in a common year and a leap year
    step("ld280223", 1'b0, 1'b1, 24'h280223, 1'b1, 24'h280223, 1'b0, 1'b0);
    step("feb23",    1'b1, 1'b0, 24'h0,      1'b1, 24'h010323, 1'b0, 1'b0);
    step("ld280224", 1'b0, 1'b1, 24'h280224, 1'b1, 24'h280224, 1'b0, 1'b0);
    step("feb24a",   1'b1, 1'b0, 24'h0,      1'b1, 24'h290224, 1'b0, 1'b0);
    step("feb24b",   1'b1, 1'b0, 24'h0,      1'b1, 24'h010324, 1'b0, 1'b0);
    step("ld280200", 1'b0, 1'b1, 24'h280200, 1'b1, 24'h280200, 1'b0, 1'b0);
    step("feb00",    1'b1, 1'b0, 24'h0,      1'b1, 24'h290200, 1'b0, 1'b0);
    step("ld280290", 1'b0, 1'b1, 24'h280290, 1'b1, 24'h280290, 1'b0, 1'b0);
    step("feb90",    1'b1, 1'b0, 24'h0,      1'b1, 24'h010390, 1'b0, 1'b0);

    // 3: century rollover, wrap pulse exactly one cycle
    step("ld311299", 1'b0, 1'b1, 24'h311299, 1'b1, 24'h311299, 1'b0, 1'b0);
    step("wrap",     1'b1, 1'b0, 24'h0,      1'b1, 24'h010100, 1'b1, 1'b0);
    step("wrap_off", 1'b0, 1'b0, 24'h0,      1'b1, 24'h010100, 1'b0, 1'b0);

    // 4: load beats a coincident tick
    step("ld_tk",    1'b1, 1'b1, 24'h090919, 1'b1, 24'h090919, 1'b0, 1'b0);
    step("tk090919", 1'b1, 1'b0, 24'h0,      1'b1, 24'h100919, 1'b0, 1'b0);

    // BCD carries and a 30-day month end
    step("ld190119", 1'b0, 1'b1, 24'h190119, 1'b1, 24'h190119, 1'b0, 1'b0);
    step("day19",    1'b1, 1'b0, 24'h0,      1'b1, 24'h200119, 1'b0, 1'b0);
    step("ld300919", 1'b0, 1'b1, 24'h300919, 1'b1, 24'h300919, 1'b0, 1'b0);
    step("sep30",    1'b1, 1'b0, 24'h0,      1'b1, 24'h011019, 1'b0, 1'b0);
    step("idle",     1'b0, 1'b0, 24'h0,      1'b1, 24'h011019, 1'b0, 1'b0);

`ifdef DATE_LOAD_CHECK_EN
    // 5: rejected loads leave the date alone and pulse load_err once
    step("bad310425", 1'b0, 1'b1, 24'h310425, 1'b1, 24'h011019, 1'b0, 1'b1);
    step("err_off",   1'b0, 1'b0, 24'h0,      1'b1, 24'h011019, 1'b0, 1'b0);
    step("bad290223", 1'b1, 1'b1, 24'h290223, 1'b1, 24'h011019, 1'b0, 1'b1);
    step("bad_nib",   1'b0, 1'b1, 24'h1A0125, 1'b1, 24'h011019, 1'b0, 1'b1);
    step("bad_mon13", 1'b0, 1'b1, 24'h011325, 1'b1, 24'h011019, 1'b0, 1'b1);
    step("bad_day00", 1'b0, 1'b1, 24'h000125, 1'b1, 24'h011019, 1'b0, 1'b1);
    step("ok300425",  1'b0, 1'b1, 24'h300425, 1'b1, 24'h300425, 1'b0, 1'b0);
    step("apr30",     1'b1, 1'b0, 24'h0,      1'b1, 24'h010525, 1'b0, 1'b0);
`else
    // 6: unchecked load of an impossible date corrects itself on the next tick
    step("ld310425",  1'b0, 1'b1, 24'h310425, 1'b1, 24'h310425, 1'b0, 1'b0);
    step("fix310425", 1'b1, 1'b0, 24'h0,      1'b1, 24'h010525, 1'b0, 1'b0);
`endif

    // A full leap year: 366 ticks from 01-01-00 lands on 01-01-01
    step("ld010100", 1'b0, 1'b1, 24'h010100, 1'b1, 24'h010100, 1'b0, 1'b0);
    for (int i = 0; i < 365; i++) begin
      step("year00", 1'b1, 1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0);
    end
    step("year00_end", 1'b1, 1'b0, 24'h0, 1'b1, 24'h010101, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
